i2c_master_ctrl: RTL and testbench

Byte-oriented I2C master that drives the SCL/SDA pair consumed by the slave top. It accepts a single-register read or write command on a simple request interface. It then generates START, address, register and data phases, ACK checking, repeated START and STOP. Bus timing comes from an internal quarter-bit tick derived from the system clock, and the block sits between the host/test logic and the I2C bus.

---
 rtl/i2c_master_ctrl_if.sv | 28 ++
 rtl/i2c_master_ctrl.sv | 162 ++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_master_ctrl_if.sv
// i2c_master_ctrl_if: request/response and SCL bundle for i2c_master_ctrl.
//   start/rw/slave_addr/reg_addr/wdata : command, sampled with start while idle
//   rdata/busy/done/ack_err            : transaction status and read result
//   SCL                                : push-pull bus clock
// SDA stays a plain inout on the master so the open-drain net resolves
// directly between the master, the slave and the pull-up.
interface i2c_master_ctrl_if;
  logic       start;
  logic       rw;
  logic [6:0] slave_addr;
  logic [7:0] reg_addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       SCL;

  modport master (
    input  start, rw, slave_addr, reg_addr, wdata,
    output rdata, busy, done, ack_err, SCL
  );

  modport slave (
    output start, rw, slave_addr, reg_addr, wdata,
    input  rdata, busy, done, ack_err, SCL
  );
endinterface

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: byte-oriented I2C master for single-register read/write.
//   clk   : system clock
//   reset : asynchronous active-low reset (aborts without STOP)
//   bus   : command/status bundle and SCL (i2c_master_ctrl_if.master)
//   SDA   : open-drain data line, only ever driven low or released
// Each bit cell is four quarter ticks of CLK_DIV clocks. SCL/SDA are
// registered and decoded from the next state so the pins never glitch.
module i2c_master_ctrl #(
  parameter int CLK_DIV = 250,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  i2c_master_ctrl_if.master bus,
  inout  wire               SDA
);
  typedef enum logic [3:0] {
    IDLE, START, ADDR_W, ACK_A, REG, ACK_R, WDATA, ACK_D,
    RSTART, ADDR_R, ACK_AR, RDATA, MNACK, STOP, DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [2:0]       bit_q, bit_d;
  logic             scl_q, scl_d;
  logic             low_q, low_d;
  logic             rw_q, nack_q, ack_err_q;
  logic [6:0]       saddr_q;
  logic [7:0]       raddr_q, wdata_q, sh_q, rdata_q, tx_byte;
  logic             busy, accept, tick, cell_end, samp, sda_in, cell_scl;

  assign sda_in   = SDA;
  assign busy     = (state_q != IDLE) && (state_q != DONE);
  assign accept   = bus.start && !busy;
  assign tick     = busy && (cnt_q == CNT_W'(CLK_DIV - 1));
  assign cell_end = tick && (qtr_q == 2'd3);
  // SDA is only changed while SCL is low, so it is stable at the end of q2.
  assign samp     = tick && (qtr_q == 2'd2);

  assign cnt_d = (!busy || tick) ? '0 : cnt_q + CNT_W'(1);
  assign qtr_d = busy ? qtr_q + 2'(tick) : 2'd0;

  // Next-state: multi-bit states leave only when the bit counter has run out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = accept ? START : IDLE;
      default: begin
        if (cell_end && bit_q == 3'd0) begin
          case (state_q)
            START:   state_d = ADDR_W;
            ADDR_W:  state_d = ACK_A;
            ACK_A:   state_d = nack_q ? STOP : REG;
            REG:     state_d = ACK_R;
            ACK_R:   state_d = nack_q ? STOP : (rw_q ? RSTART : WDATA);
            WDATA:   state_d = ACK_D;
            ACK_D:   state_d = STOP;
            RSTART:  state_d = ADDR_R;
            ADDR_R:  state_d = ACK_AR;
            ACK_AR:  state_d = nack_q ? STOP : RDATA;
            RDATA:   state_d = MNACK;
            MNACK:   state_d = STOP;
            default: state_d = DONE;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    bit_d = bit_q;
    if (!busy) bit_d = 3'd0;
    else if (cell_end) begin
      if (bit_q != 3'd0) bit_d = bit_q - 3'd1;
      else if (state_d inside {ADDR_W, REG, WDATA, ADDR_R, RDATA}) bit_d = 3'd7;
      else bit_d = 3'd0;
    end
  end

  always_comb begin
    case (state_d)
      ADDR_W:  tx_byte = {saddr_q, 1'b0};
      REG:     tx_byte = raddr_q;
      ADDR_R:  tx_byte = {saddr_q, 1'b1};
      default: tx_byte = wdata_q;
    endcase
  end

  // Pin decode for the upcoming cycle. START keeps SCL high for the whole
  // cell so the first SCL fall coincides with the first address bit.
  always_comb begin
    scl_d    = 1'b1;
    low_d    = 1'b0;
    cell_scl = qtr_d[0] ^ qtr_d[1];
    case (state_d)
      START:                      low_d = qtr_d[1];
      ADDR_W, REG, WDATA, ADDR_R: begin
        scl_d = cell_scl;
        low_d = ~tx_byte[bit_d];
      end
      ACK_A, ACK_R, ACK_D, ACK_AR, RDATA, MNACK: scl_d = cell_scl;
      RSTART: begin
        scl_d = cell_scl;
        low_d = qtr_d[1];
      end
      STOP: begin
        scl_d = (qtr_d != 2'd0);
        low_d = (qtr_d != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      qtr_q     <= 2'd0;
      bit_q     <= 3'd0;
      scl_q     <= 1'b1;
      low_q     <= 1'b0;
      rw_q      <= 1'b0;
      saddr_q   <= 7'h00;
      raddr_q   <= 8'h00;
      wdata_q   <= 8'h00;
      sh_q      <= 8'h00;
      rdata_q   <= 8'h00;
      nack_q    <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      scl_q   <= scl_d;
      low_q   <= low_d;
      if (accept) begin
        rw_q      <= bus.rw;
        saddr_q   <= bus.slave_addr;
        raddr_q   <= bus.reg_addr;
        wdata_q   <= bus.wdata;
        nack_q    <= 1'b0;
        ack_err_q <= 1'b0;
      end
      if (samp && (state_q inside {ACK_A, ACK_R, ACK_D, ACK_AR}) && sda_in) nack_q <= 1'b1;
      if (samp && state_q == RDATA) sh_q <= {sh_q[6:0], sda_in};
      // Status becomes visible together with done.
      if (state_q == STOP && state_d == DONE) begin
        ack_err_q <= nack_q;
        if (rw_q && !nack_q) rdata_q <= sh_q;
      end
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = (state_q == DONE);
  assign bus.ack_err = ack_err_q;
  assign bus.rdata   = rdata_q;
  assign bus.SCL     = scl_q;
  assign SDA         = low_q ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: directed bench for i2c_master_ctrl. A clk-sampled
// slave model at address 0x50 ACKs bytes, returns rd_byte on reads and logs
// bus traffic (-1 = START, -2 = STOP, else byte). A second DUT with
// CLK_DIV=2 and no slave covers START timing and back-to-back commands.
module tb_i2c_master_ctrl;
  localparam int         DIV  = 5;
  localparam int         DIV2 = 2;
  localparam logic [6:0] SLV  = 7'h50;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  i2c_master_ctrl_if bus ();
  i2c_master_ctrl_if bus2 ();
  wire sda, sda2;
  pullup (sda);
  pullup (sda2);
  logic drv = 1'b0;
  assign sda = drv ? 1'b0 : 1'bz;

  i2c_master_ctrl #(.CLK_DIV(DIV), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .SDA(sda));
  i2c_master_ctrl #(.CLK_DIV(DIV2), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2), .SDA(sda2));

  int total = 0;
  int bad = 0;

  // ---------------- slave model ----------------
  int         log_q[$];
  logic [7:0] rd_byte = 8'hC3;
  logic       p_scl = 1'b1, p_sda = 1'b1;
  logic       started = 1'b0, addressed = 1'b0, rd_mode = 1'b0;
  logic [7:0] shreg = 8'h00;
  int         bitcnt = 0, byte_idx = 0;

  always @(negedge clk) begin
    logic s_scl, s_sda;
    s_scl = bus.SCL;
    s_sda = sda;
    if (p_scl && s_scl && p_sda && !s_sda) begin
      log_q.push_back(-1);
      started = 1'b1; addressed = 1'b0; rd_mode = 1'b0;
      bitcnt = 0; byte_idx = 0; drv = 1'b0;
    end else if (p_scl && s_scl && !p_sda && s_sda) begin
      if (started) log_q.push_back(-2);
      started = 1'b0; addressed = 1'b0; drv = 1'b0;
    end else if (started && !p_scl && s_scl) begin
      if (bitcnt < 8) shreg = {shreg[6:0], s_sda};
      bitcnt++;
    end else if (started && p_scl && !s_scl) begin
      if (bitcnt == 8) begin
        log_q.push_back(int'(shreg));
        if (byte_idx == 0) begin
          addressed = (shreg[7:1] == SLV);
          rd_mode = shreg[0];
        end
        drv = addressed && !(rd_mode && byte_idx > 0);
        byte_idx++;
      end else if (bitcnt == 9) begin
        bitcnt = 0;
        drv = addressed && rd_mode && (byte_idx == 1) && !rd_byte[7];
      end else if (addressed && rd_mode && byte_idx == 1 && bitcnt >= 1 && bitcnt <= 7) begin
        drv = !rd_byte[7-bitcnt];
      end
    end
    p_scl = s_scl;
    p_sda = s_sda;
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic r, input logic [6:0] sa, input logic [7:0] ra,
                       input logic [7:0] wd);
    bus.rw = r; bus.slave_addr = sa; bus.reg_addr = ra; bus.wdata = wd;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n, output bit seen);
    n = 0; seen = 1'b0;
    while (!seen && n < limit) begin
      @(posedge clk); #1;
      n++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    #12;
    total++; if (bus.SCL !== 1'b1) begin bad++; $display("FAIL reset_scl got=%b exp=1", bus.SCL); end
    total++; if (sda !== 1'b1) begin bad++; $display("FAIL reset_sda got=%b exp=1", sda); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.ack_err !== 1'b0) begin bad++; $display("FAIL reset_ack_err got=%b exp=0", bus.ack_err); end
    total++; if (bus.rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h exp=00", bus.rdata); end
    total++; if (bus2.SCL !== 1'b1) begin bad++; $display("FAIL reset_scl2 got=%b exp=1", bus2.SCL); end
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_write();
    int n; bit seen;
    int exp_q[$];
    exp_q = '{-1, 'hA0, 'h03, 'h5A, -2};
    log_q.delete();
    issue(1'b0, 7'h50, 8'h03, 8'h5A);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL wr_busy got=%b exp=1", bus.busy); end
    wait_done(200*DIV, n, seen);
    total++; if (!seen || n != 116*DIV) begin bad++; $display("FAIL wr_latency seen=%0d got=%0d exp=%0d", seen, n, 116*DIV); end
    total++; if (bus.ack_err !== 1'b0) begin bad++; $display("FAIL wr_ack_err got=%b exp=0", bus.ack_err); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL wr_busy_at_done got=%b exp=0", bus.busy); end
    total++; if (log_q.size() != exp_q.size()) begin bad++; $display("FAIL wr_log_len got=%0d exp=%0d", log_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      total++; if (log_q[i] != exp_q[i]) begin bad++; $display("FAIL wr_log[%0d] got=%0h exp=%0h", i, log_q[i], exp_q[i]); end
    end
    @(posedge clk); #1;
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL wr_done_pulse got=%b exp=0", bus.done); end
    total++; if (bus.SCL !== 1'b1 || sda !== 1'b1) begin bad++; $display("FAIL wr_bus_idle scl=%b sda=%b exp=1/1", bus.SCL, sda); end
  endtask

  task automatic test_read();
    int n; bit seen;
    int exp_q[$];
    exp_q = '{-1, 'hA0, 'h03, -1, 'hA1, 'hC3, -2};
    rd_byte = 8'hC3;
    log_q.delete();
    issue(1'b1, 7'h50, 8'h03, 8'h00);
    wait_done(200*DIV, n, seen);
    total++; if (!seen || n != 156*DIV) begin bad++; $display("FAIL rd_latency seen=%0d got=%0d exp=%0d", seen, n, 156*DIV); end
    total++; if (bus.rdata !== 8'hC3) begin bad++; $display("FAIL rd_rdata got=%h exp=c3", bus.rdata); end
    total++; if (bus.ack_err !== 1'b0) begin bad++; $display("FAIL rd_ack_err got=%b exp=0", bus.ack_err); end
    total++; if (log_q.size() != exp_q.size()) begin bad++; $display("FAIL rd_log_len got=%0d exp=%0d", log_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      total++; if (log_q[i] != exp_q[i]) begin bad++; $display("FAIL rd_log[%0d] got=%0h exp=%0h", i, log_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_addr_nack();
    int n; bit seen;
    int exp_q[$];
    exp_q = '{-1, 'h42, -2};
    log_q.delete();
    issue(1'b1, 7'h21, 8'h03, 8'h00);
    wait_done(200*DIV, n, seen);
    total++; if (!seen || n != 44*DIV) begin bad++; $display("FAIL nack_latency seen=%0d got=%0d exp=%0d", seen, n, 44*DIV); end
    total++; if (bus.ack_err !== 1'b1) begin bad++; $display("FAIL nack_ack_err got=%b exp=1", bus.ack_err); end
    total++; if (bus.rdata !== 8'hC3) begin bad++; $display("FAIL nack_rdata_kept got=%h exp=c3", bus.rdata); end
    total++; if (log_q.size() != exp_q.size()) begin bad++; $display("FAIL nack_log_len got=%0d exp=%0d", log_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      total++; if (log_q[i] != exp_q[i]) begin bad++; $display("FAIL nack_log[%0d] got=%0h exp=%0h", i, log_q[i], exp_q[i]); end
    end
    @(posedge clk); #1;
    total++; if (bus.ack_err !== 1'b1) begin bad++; $display("FAIL nack_ack_err_held got=%b exp=1", bus.ack_err); end
  endtask

  task automatic test_ignore_busy();
    int ndone;
    int exp_q[$];
    exp_q = '{-1, 'hA0, 'h22, 'h11, -2};
    log_q.delete();
    issue(1'b0, 7'h50, 8'h22, 8'h11);
    total++; if (bus.ack_err !== 1'b0) begin bad++; $display("FAIL ign_ack_err_clear got=%b exp=0", bus.ack_err); end
    ndone = 0;
    for (int c = 0; c < 116*DIV + 40; c++) begin
      if (c == 100) begin
        bus.rw = 1'b1; bus.slave_addr = 7'h33; bus.reg_addr = 8'h44; bus.wdata = 8'h55;
        bus.start = 1'b1;
      end
      if (c == 101) bus.start = 1'b0;
      @(posedge clk); #1;
      if (bus.done === 1'b1) ndone++;
    end
    total++; if (ndone != 1) begin bad++; $display("FAIL ign_done_count got=%0d exp=1", ndone); end
    total++; if (log_q.size() != exp_q.size()) begin bad++; $display("FAIL ign_log_len got=%0d exp=%0d", log_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      total++; if (log_q[i] != exp_q[i]) begin bad++; $display("FAIL ign_log[%0d] got=%0h exp=%0h", i, log_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_abort();
    int n; bit seen;
    int exp_q[$];
    exp_q = '{-1, 'hA0, 'h04, 'h3C, -2};
    issue(1'b0, 7'h50, 8'h88, 8'h99);
    repeat (12*4*DIV) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    total++; if (bus.SCL !== 1'b1) begin bad++; $display("FAIL abort_scl got=%b exp=1", bus.SCL); end
    total++; if (sda !== 1'b1) begin bad++; $display("FAIL abort_sda got=%b exp=1", sda); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    total++; if (bus.rdata !== 8'h00) begin bad++; $display("FAIL abort_rdata got=%h exp=00", bus.rdata); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    log_q.delete();
    issue(1'b0, 7'h50, 8'h04, 8'h3C);
    wait_done(200*DIV, n, seen);
    total++; if (!seen || n != 116*DIV) begin bad++; $display("FAIL abort_wr_latency seen=%0d got=%0d exp=%0d", seen, n, 116*DIV); end
    total++; if (bus.ack_err !== 1'b0) begin bad++; $display("FAIL abort_wr_ack_err got=%b exp=0", bus.ack_err); end
    total++; if (log_q.size() != exp_q.size()) begin bad++; $display("FAIL abort_log_len got=%0d exp=%0d", log_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      total++; if (log_q[i] != exp_q[i]) begin bad++; $display("FAIL abort_log[%0d] got=%0h exp=%0h", i, log_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int n, first_fall; bit seen;
    bus2.rw = 1'b0; bus2.slave_addr = 7'h50; bus2.reg_addr = 8'h01; bus2.wdata = 8'h02;
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin
        @(posedge clk); #1;
      end
      bus2.start = 1'b1;
      @(posedge clk); #1;
      bus2.start = 1'b0;
      total++; if (bus2.busy !== 1'b1) begin bad++; $display("FAIL b2b_busy[%0d] got=%b exp=1", k, bus2.busy); end
      n = 0; first_fall = -1; seen = 1'b0;
      while (!seen && n < 400) begin
        @(posedge clk); #1;
        n++;
        if (first_fall < 0 && bus2.SCL === 1'b0) first_fall = n;
        if (bus2.done === 1'b1) seen = 1'b1;
      end
      total++; if (first_fall != 4*DIV2) begin bad++; $display("FAIL b2b_start_time[%0d] got=%0d exp=%0d", k, first_fall, 4*DIV2); end
      total++; if (!seen || n != 44*DIV2) begin bad++; $display("FAIL b2b_latency[%0d] seen=%0d got=%0d exp=%0d", k, seen, n, 44*DIV2); end
      total++; if (bus2.ack_err !== 1'b1) begin bad++; $display("FAIL b2b_ack_err[%0d] got=%b exp=1", k, bus2.ack_err); end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.rw = 1'b0; bus.slave_addr = 7'h00; bus.reg_addr = 8'h00; bus.wdata = 8'h00;
    bus2.start = 1'b0; bus2.rw = 1'b0; bus2.slave_addr = 7'h00; bus2.reg_addr = 8'h00; bus2.wdata = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_ignore_busy();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
